// File: rtl/fixed_round_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_round_pkg
//  Description : Shared constants, types and helpers for the fixed-point
//                round-to-nearest block: representation names and the
//                saturation-bound calculation.
//  Revision    : 1.0 - initial release
// ============================================================================
package fixed_round_pkg;

  // Accepted values of the SIGNREP parameter.
  localparam string c_SIGNREP_SIGNED   = "SIGNED";
  localparam string c_SIGNREP_UNSIGNED = "UNSIGNED";

  // Widest output the bound helper can describe (bounds held in 64 bits).
  localparam int c_MAX_OWIDTH = 62;

  // Inclusive saturation limits for a result word.
  typedef struct packed {
    logic signed [63:0] hi;
    logic signed [63:0] lo;
  } sat_bounds_t;

  // Largest and smallest representable value of a WIDTH-bit word in the
  // chosen representation.
  function automatic sat_bounds_t sat_bounds(input int width, input logic is_signed);
    sat_bounds_t b;
    if (is_signed) begin
      b.hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      b.lo = -(64'sd1 <<< (width - 1));
    end else begin
      b.hi = (64'sd1 <<< width) - 64'sd1;
      b.lo = 64'sd0;
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fixed_round_delay.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_round_delay
//  Description : WIDTH x DEPTH register chain with asynchronous active-low
//                reset and clock enable.  DEPTH=0 degenerates to a wire.
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_round_delay #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,       // active-low, asynchronous
  input  logic             i_clkena,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      // No registers requested: the chain is a straight connection.
      assign o_data = i_data;
    end else begin : g_chain
      logic [WIDTH-1:0] r_stage [DEPTH];

      // Shift chain: every stage advances together on an enabled edge and
      // all stages clear immediately when reset is asserted.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_stage[i] <= '0;
          end
        end else if (i_clkena) begin
          r_stage[0] <= i_data;
          for (int i = 1; i < DEPTH; i++) begin
            r_stage[i] <= r_stage[i-1];
          end
        end
      end

      assign o_data = r_stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/fixed_round_nearest.sv
`default_nettype none
// ============================================================================
//  Module      : fixed_round_nearest
//  Description : Drops the IWIDTH-OWIDTH fractional LSBs of i_data with
//                round-to-nearest (half up for unsigned, half away from zero
//                for signed), saturates to OWIDTH bits, then delays the
//                result by PIPELINE enabled clock edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module fixed_round_nearest
  import fixed_round_pkg::*;
#(
  parameter int    IWIDTH   = 7,
  parameter int    OWIDTH   = 4,
  parameter string SIGNREP  = "UNSIGNED",
  parameter int    PIPELINE = 3
) (
  input  logic              clk,
  input  logic              rst,       // active-low, asynchronous
  input  logic              clkena,
  input  logic [IWIDTH-1:0] i_data,
  output logic [OWIDTH-1:0] o_data
);

  // Number of fractional bits discarded and width of the pre-clamp quotient.
  localparam int   c_D         = IWIDTH - OWIDTH;
  localparam int   c_RW        = OWIDTH + 1;
  localparam logic c_IS_SIGNED = (SIGNREP == c_SIGNREP_SIGNED);
  localparam logic c_REP_VALID = c_IS_SIGNED || (SIGNREP == c_SIGNREP_UNSIGNED);

  // Elaboration-time parameter checks.
  generate
    if (!c_REP_VALID) begin : g_bad_signrep
      $error("fixed_round_nearest: SIGNREP must be \"SIGNED\" or \"UNSIGNED\"");
    end
    if (OWIDTH < 1 || OWIDTH > c_MAX_OWIDTH) begin : g_bad_owidth
      $error("fixed_round_nearest: OWIDTH out of range");
    end
    if (IWIDTH < OWIDTH) begin : g_bad_iwidth
      $error("fixed_round_nearest: IWIDTH must be >= OWIDTH");
    end
    if (PIPELINE < 0) begin : g_bad_pipeline
      $error("fixed_round_nearest: PIPELINE must be >= 0");
    end
  endgenerate

  logic [OWIDTH-1:0] w_round;

  generate
    if (c_D == 0) begin : g_identity
      // Nothing to discard: the word passes through unchanged.
      assign w_round = i_data;

    end else if (!c_IS_SIGNED) begin : g_unsigned
      localparam sat_bounds_t       c_B    = sat_bounds(OWIDTH, 1'b0);
      localparam logic [c_RW-1:0]   c_HI   = c_RW'(c_B.hi);
      localparam logic [IWIDTH:0]   c_HALF = (IWIDTH + 1)'(1) << (c_D - 1);

      logic [IWIDTH:0]   w_sum;
      logic [c_RW-1:0]   w_q;

      // Round half up: add half an output LSB in a one-bit-wider adder so
      // the carry out of the top bit is kept rather than wrapped.
      assign w_sum = {1'b0, i_data} + c_HALF;
      assign w_q   = w_sum[IWIDTH:c_D];

      // Only the top quotient bit can push the value past the output range.
      assign w_round = (w_q > c_HI) ? c_HI[OWIDTH-1:0] : w_q[OWIDTH-1:0];

    end else begin : g_signed
      localparam sat_bounds_t            c_B    = sat_bounds(OWIDTH, 1'b1);
      localparam logic signed [c_RW-1:0] c_HI   = c_RW'(c_B.hi);
      localparam logic signed [c_RW-1:0] c_LO   = c_RW'(c_B.lo);
      localparam logic signed [IWIDTH:0] c_HALF = (IWIDTH + 1)'(1) << (c_D - 1);
      localparam logic [c_D-1:0]         c_TIE  = c_D'(1) << (c_D - 1);

      logic                     w_neg;
      logic                     w_tie;
      logic signed [IWIDTH:0]   w_ext;
      logic signed [IWIDTH:0]   w_tie_ext;
      logic signed [IWIDTH:0]   w_sum;
      logic signed [c_RW-1:0]   w_q;
      logic [OWIDTH-1:0]        w_clamp;

      // Sign-extend one bit so the bias addition can never overflow.
      assign w_neg     = i_data[IWIDTH-1];
      assign w_ext     = {w_neg, i_data};

      // A negative exact half must round away from zero (downwards), so the
      // half-LSB bias is reduced by one in that single case.
      assign w_tie     = w_neg && (i_data[c_D-1:0] == c_TIE);
      assign w_tie_ext = {{IWIDTH{1'b0}}, w_tie};
      assign w_sum     = w_ext + c_HALF - w_tie_ext;

      // Taking the upper bits is an arithmetic right shift by D.
      assign w_q = w_sum[IWIDTH:c_D];

      // Clamp to the signed output range; the low clamp is kept as a guard
      // even though half-away-from-zero rounding cannot underflow.
      always_comb begin
        w_clamp = w_q[OWIDTH-1:0];
        if (w_q > c_HI) begin
          w_clamp = c_HI[OWIDTH-1:0];
        end else if (w_q < c_LO) begin
          w_clamp = c_LO[OWIDTH-1:0];
        end
      end

      assign w_round = w_clamp;
    end
  endgenerate

  // Output latency chain; PIPELINE=0 keeps the path combinational.
  fixed_round_delay #(
    .WIDTH (OWIDTH),
    .DEPTH (PIPELINE)
  ) u_delay (
    .clk      (clk),
    .rst      (rst),
    .i_clkena (clkena),
    .i_data   (w_round),
    .o_data   (o_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_fixed_round_nearest.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fixed_round_nearest
//  Description : Self-checking bench for fixed_round_nearest.  Five DUT
//                configurations share one stimulus stream; a queue of sampled
//                inputs plus an arithmetic rounding model supply expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fixed_round_nearest;

  logic       clk;
  logic       rst;
  logic       clkena;
  logic [6:0] din;
  logic [3:0] o_u, o_s, o_p0, o_id, o_s5;

  int n_cmp;
  int n_err;

  // Raw inputs taken on enabled edges since reset; -1 marks a reset slot.
  int samp_q[$];

  typedef struct {
    logic [6:0] din;
    int         sel;    // 0=unsigned 7/4, 1=signed 7/4, 2=signed 5/4, 3=4/4
    logic [3:0] exp;
    string      name;
  } vec_t;
  vec_t vecs[$];

  fixed_round_nearest #(.IWIDTH(7), .OWIDTH(4), .SIGNREP("UNSIGNED"), .PIPELINE(3)) u_dut_u (
    .clk(clk), .rst(rst), .clkena(clkena), .i_data(din), .o_data(o_u));
  fixed_round_nearest #(.IWIDTH(7), .OWIDTH(4), .SIGNREP("SIGNED"), .PIPELINE(3)) u_dut_s (
    .clk(clk), .rst(rst), .clkena(clkena), .i_data(din), .o_data(o_s));
  fixed_round_nearest #(.IWIDTH(7), .OWIDTH(4), .SIGNREP("UNSIGNED"), .PIPELINE(0)) u_dut_p0 (
    .clk(clk), .rst(rst), .clkena(clkena), .i_data(din), .o_data(o_p0));
  fixed_round_nearest #(.IWIDTH(4), .OWIDTH(4), .SIGNREP("UNSIGNED"), .PIPELINE(3)) u_dut_id (
    .clk(clk), .rst(rst), .clkena(clkena), .i_data(din[3:0]), .o_data(o_id));
  fixed_round_nearest #(.IWIDTH(5), .OWIDTH(4), .SIGNREP("SIGNED"), .PIPELINE(3)) u_dut_s5 (
    .clk(clk), .rst(rst), .clkena(clkena), .i_data(din[4:0]), .o_data(o_s5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Round-to-nearest from the numeric definition: scale by 2^-D, round the
  // magnitude half up, restore the sign, clamp, then wrap to ow bits.
  function automatic int ref_round(int x, int iw, int ow, bit sgn);
    int d, v, a, m, r, hi, lo;
    d = iw - ow;
    x = x % (1 << iw);
    v = (sgn && x >= (1 << (iw - 1))) ? x - (1 << iw) : x;
    if (d == 0) begin
      r = v;
    end else begin
      a = (v < 0) ? -v : v;
      m = (a + (1 << (d - 1))) / (1 << d);
      r = (v < 0) ? -m : m;
    end
    hi = sgn ? (1 << (ow - 1)) - 1 : (1 << ow) - 1;
    lo = sgn ? -(1 << (ow - 1)) : 0;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return r & ((1 << ow) - 1);
  endfunction

  function automatic logic [3:0] exp_delayed(int iw, bit sgn);
    if (samp_q[0] < 0) return 4'd0;
    return 4'(ref_round(samp_q[0], iw, 4, sgn));
  endfunction

  task automatic check(string name, logic [3:0] act, logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (din=%h t=%0t)", name, act, exp, din, $time);
    end
  endtask

  task automatic check_all();
    check("unsigned_p3", o_u,  exp_delayed(7, 1'b0));
    check("signed_p3",   o_s,  exp_delayed(7, 1'b1));
    check("ident_4_4",   o_id, exp_delayed(4, 1'b0));
    check("signed_5_4",  o_s5, exp_delayed(5, 1'b1));
    check("comb_p0",     o_p0, 4'(ref_round(int'(din), 7, 4, 1'b0)));
  endtask

  task automatic model_reset();
    samp_q = '{-1, -1, -1};
  endtask

  // One clock: model follows the enabled edge, outputs compared on negedge.
  task automatic step();
    @(posedge clk);
    if (rst && clkena) begin
      samp_q.push_back(int'(din));
      void'(samp_q.pop_front());
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic void add_vec(logic [6:0] d, int sel, logic [3:0] e, string n);
    vec_t v;
    v.din = d; v.sel = sel; v.exp = e; v.name = n;
    vecs.push_back(v);
  endfunction

  logic [3:0] held;
  logic [3:0] sel_out;

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b0;
    clkena = 1'b1;
    din    = '0;
    model_reset();

    add_vec(7'd3,   0, 4'd0,  "u_3");
    add_vec(7'd4,   0, 4'd1,  "u_4");
    add_vec(7'd11,  0, 4'd1,  "u_11");
    add_vec(7'd12,  0, 4'd2,  "u_12");
    add_vec(7'd20,  0, 4'd3,  "u_20");
    add_vec(7'd123, 0, 4'd15, "u_123");
    add_vec(7'd124, 0, 4'd15, "u_124_sat");
    add_vec(7'd127, 0, 4'd15, "u_127");
    add_vec(7'h7C,  1, 4'hF,  "s_m0p5");
    add_vec(7'h74,  1, 4'hE,  "s_m1p5");
    add_vec(7'h7D,  1, 4'h0,  "s_m0p375");
    add_vec(7'h40,  1, 4'h8,  "s_m64");
    add_vec(7'h3B,  1, 4'h7,  "s_7p375");
    add_vec(7'h3C,  1, 4'h7,  "s_7p5_sat");
    add_vec(7'h3F,  1, 4'h7,  "s_3f");
    add_vec(7'h1F,  2, 4'hF,  "s5_m0p5");
    add_vec(7'h09,  3, 4'h9,  "id_9");

    // Reset state, held over a couple of clocks.
    @(negedge clk);
    check_all();
    step();
    rst = 1'b1;

    // First valid output three enabled edges after the first sampled input.
    din = 7'd12;
    step();
    check("rst_release_e1", o_u, 4'd0);
    din = 7'd20;
    step();
    check("rst_release_e2", o_u, 4'd0);
    din = 7'd0;
    step();
    check("rst_release_e3", o_u, 4'd2);

    // Full input sweep.
    for (int v = 0; v < 128; v++) begin
      din = 7'(v);
      step();
    end

    // Table-driven rounding points: hold each input for the full latency.
    for (int i = 0; i < vecs.size(); i++) begin
      din = vecs[i].din;
      for (int k = 0; k < 3; k++) step();
      case (vecs[i].sel)
        0:       sel_out = o_u;
        1:       sel_out = o_s;
        2:       sel_out = o_s5;
        default: sel_out = o_id;
      endcase
      check(vecs[i].name, sel_out, vecs[i].exp);
    end

    // Latency: flush with zeros, then 12 appears as 2 on the third edge.
    din = 7'd0;
    for (int k = 0; k < 3; k++) step();
    din = 7'd12;
    step();
    din = 7'd0;
    check("lat_e1", o_u, 4'd0);
    step();
    check("lat_e2", o_u, 4'd0);
    step();
    check("lat_e3", o_u, 4'd2);
    step();
    check("lat_e4", o_u, 4'd0);

    // Clock enable: stall two cycles mid-stream; outputs freeze, delay stretches.
    din = 7'd100;
    step();
    din = 7'd36;
    step();
    din = 7'd60;
    step();
    held   = o_u;
    clkena = 1'b0;
    din    = 7'd5;
    step();
    check("hold_1", o_u, held);
    step();
    check("hold_2", o_u, held);
    clkena = 1'b1;
    din = 7'd0;
    step();
    check("resume_1", o_u, 4'd5);
    step();
    check("resume_2", o_u, 4'd8);

    // Asynchronous reset between edges clears the outputs at once.
    din = 7'h3F;
    for (int k = 0; k < 3; k++) step();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check("async_rst_u", o_u,  4'd0);
    check("async_rst_s", o_s,  4'd0);
    check("async_rst_id", o_id, 4'd0);
    step();
    rst = 1'b1;
    din = 7'd124;
    step();
    check("post_rst_1", o_u, 4'd0);
    step();
    check("post_rst_2", o_u, 4'd0);
    step();
    check("post_rst_3", o_u, 4'd15);

    // Random stimulus with sporadic clock-enable drops.
    for (int k = 0; k < 400; k++) begin
      din    = 7'($urandom_range(0, 127));
      clkena = ($urandom_range(0, 9) < 8);
      step();
    end
    clkena = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fixed_round_nearest.md
Name: fixed_round_nearest

Overview:
Fixed-point round-to-nearest block. It drops the (IWIDTH-OWIDTH) fractional LSBs of an input word, giving an OWIDTH-bit result that saturates on overflow. The result passes through a programmable-depth pipeline with clock enable. It sits in DSP datapaths after accumulators and multipliers, wherever word width must shrink without truncation bias.

Parameters:
IWIDTH, 7, input data width; must be >= OWIDTH and >= 1.
OWIDTH, 4, output data width; must be >= 1.
SIGNREP, "UNSIGNED", data representation, either "UNSIGNED" or "SIGNED" (two's complement). Any other value is a elaboration error.
PIPELINE, 3, latency in clock cycles; 0 means a purely combinational path.

Ports:
clk     input   1        clock; all registers update on the rising edge.
rst     input   1        reset; asynchronous, active-low. rst=0 clears all pipeline registers.
clkena  input   1        clock enable; 1 advances the pipeline, 0 holds all registers.
i_data  input   IWIDTH   input word; its low D=IWIDTH-OWIDTH bits are fractional.
o_data  output  OWIDTH   rounded, saturated result.

Behaviour:
- Let D = IWIDTH-OWIDTH.
- D=0: the rounding function is identity; only the pipeline delay applies.
- UNSIGNED rounding (round half up):
  - r = (i_data + 2^(D-1)) >> D, computed with OWIDTH+1 bits.
  - If r > 2^OWIDTH-1, o = 2^OWIDTH-1 (saturate).
- SIGNED rounding (round half away from zero):
  - Positive/zero input: r = (x + 2^(D-1)) >> D (arithmetic shift).
  - Negative input: r = -((|x| + 2^(D-1)) >> D). Equivalently, add 2^(D-1), subtract 1 if the discarded bits equal exactly 1000..0 and the sign is negative, then shift.
  - If r > 2^(OWIDTH-1)-1, o = 2^(OWIDTH-1)-1.
  - Negative overflow cannot occur. Clamping to -2^(OWIDTH-1) is still required for safety.
- Internal arithmetic is one bit wider than the input; no wrap-around is permitted anywhere.
- Pipeline:
  - The rounding function is combinational. Its result goes through a PIPELINE-stage register chain.
  - o_data equals f(i_data sampled PIPELINE enabled edges earlier).
  - PIPELINE=0: o_data = f(i_data) combinationally.
- clkena=0: every stage holds its value and o_data is frozen. Latency counts enabled edges only.
- Reset:
  - While rst=0, all stages are 0, so o_data=0 immediately, asynchronously, for PIPELINE>0.
  - Reset mid-stream discards all in-flight data. The first valid output appears PIPELINE enabled edges after release.
- X on i_data propagates as X; there is no X-masking requirement.

Decomposition:
- Package fixed_round_pkg holds:
  - SIGNREP string constants ("SIGNED", "UNSIGNED").
  - A function returning the saturation bounds for a given width and representation.
- One natural sub-module, fixed_round_delay: a parameterized WIDTH x DEPTH register chain with async active-low reset and clkena. It must support DEPTH=0 as a wire-through.
- The rounding core stays in the top module.

Test Plan:
Defaults for all scenarios are IWIDTH=7, OWIDTH=4, PIPELINE=3, clkena=1. Sweep i_data 0..127 one value per clock after reset release, and compare against a behavioural model delayed 3 cycles.
- UNSIGNED rounding points:
  - 3 -> 0, 4 -> 1, 11 -> 1, 12 -> 2, 20 -> 3.
  - 123 -> 15; 124 (15.5) -> 15, saturated; 127 -> 15.
- SIGNED rounding points:
  - 0x7C (-0.5) -> 0xF (-1); 0x74 (-1.5) -> 0xE (-2); 0x7D (-0.375) -> 0x0.
  - 0x40 (-64) -> 0x8 (-8); 0x3B (7.375) -> 7; 0x3C (7.5) -> 7, saturated; 0x3F -> 7.
- Latency and clkena:
  - Apply 12 at edge n; o_data=2 exactly after edge n+3.
  - Drop clkena for 2 cycles mid-stream; output holds, then resumes with the delay extended by 2.
- Reset:
  - Assert rst=0 asynchronously between edges; o_data goes to 0 immediately.
  - After release, o_data stays 0 until 3 enabled edges after the first sampled input.
- Parameter corners:
  - PIPELINE=0: combinational, same-cycle match.
  - IWIDTH=OWIDTH=4: pass-through after the pipeline delay.
  - IWIDTH=5, OWIDTH=4 signed: 0x1F (-0.5) -> 0xF.
